smol_fetch: RTL and testbench
=============================

Name: smol_fetch

Overview:
- Instruction-fetch front end: the consumer of the program counter and the producer of next_pc for smolPC.
- Each cycle it reads the registered pc, issues instruction-memory reads with a valid/ready handshake, and buffers returned words in a small FIFO.
- It presents instructions with their PCs to decode and computes next_pc: sequential, held, or redirected by branch/jump.
- It sits between smolPC, the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on next_pc while rst is high; must match smolPC's reset value.
- FIFO_DEPTH, 2, number of instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC from smolPC.
- next_pc  out  32  PC value smolPC loads on the next edge (combinational).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  read address; equals pc.
- imem_rsp_valid  in  1  read data valid; at most one response per accepted request, in order.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  buffered instruction available.
- inst_ready  in  1  decode consumes the instruction.
- inst_data  out  32  FIFO head instruction.
- inst_pc  out  32  FIFO head PC.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- While rst is high:
  - next_pc = RESET_PC; imem_req_valid = 0; inst_valid = 0.
  - FIFO empty; state = S_REQ; no outstanding request.
  - inst_data and inst_pc = 0.
- Reset asserted mid-transaction: the outstanding request is forgotten. A response arriving after rst deasserts is still dropped, because the drop flag is set by reset whenever a request was outstanding.
- Only one request may be outstanding.

State machine:
- S_REQ:
  - imem_req_valid = 1 iff FIFO occupancy < FIFO_DEPTH and redirect_valid = 0.
  - On handshake: capture pc into req_pc, go to S_WAIT.
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid: push {imem_rsp_data, req_pc} into the FIFO, go to S_REQ.
- S_DROP:
  - imem_req_valid = 0.
  - On imem_rsp_valid: discard the word, go to S_REQ.

next_pc priority (combinational):
1. rst → RESET_PC.
2. redirect_valid → {redirect_pc[31:2], 2'b00}.
3. Request handshake this cycle → pc + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
4. Otherwise → pc (hold).

Redirect (same edge as the PC load):
- FIFO flushed; inst_valid is 0 next cycle.
- S_WAIT → S_DROP.
- In S_REQ, no request is issued that cycle (valid is suppressed).
- Redirect coincident with imem_rsp_valid in S_WAIT: the response is discarded, go to S_REQ.
- Redirect in S_DROP: stay in S_DROP.

FIFO:
- Push and pop in the same cycle are legal at any occupancy, including full.
- Pop occurs when inst_valid && inst_ready.
- inst_* reflect the head with no bypass: fetch-to-decode latency is 1 cycle after the rsp edge.
- A push to a full FIFO cannot occur, because requests are gated on occupancy < FIFO_DEPTH.
- Best-case throughput with single-cycle memory: one instruction per 2 cycles. Accepted limitation.

Decomposition:
- Shared package smol_pkg:
  - XLEN = 32, INST_BYTES = 4, RESET_PC default.
  - typedef fetch_state_t {S_REQ, S_WAIT, S_DROP}.
  - typedef struct fetch_entry_t {logic [31:0] inst; logic [31:0] pc;}.
- One sub-module: smol_fetch_fifo. Synchronous FIFO of fetch_entry_t with parameter DEPTH and ports push, pop, flush, full, empty, count, head. flush has priority over push.

Test Plan:
- Reset and first fetch: rst high 2 cycles then low; memory ready=1, responds 1 cycle later with 32'h0000_0013 → next_pc = 0 during reset, imem_addr = 0; inst_valid with inst_pc = 0, inst_data = 32'h13; next_pc advances 0 → 4 → 8.
- Backpressure: inst_ready = 0 for 10 cycles → after 2 pushes, imem_req_valid = 0 and next_pc holds at 8; raising inst_ready drains PCs 0 and 4 in order, then fetching resumes at 8.
- Redirect during S_WAIT: request at pc = 4 outstanding, redirect_pc = 32'h1234_5679 → next_pc = 32'h1234_5678; the late response for address 4 never appears on inst_*; the next inst_pc is 32'h1234_5678.
- Redirect coincident with the response: imem_rsp_valid and redirect_valid in the same cycle → no push, state S_REQ, next request at the redirect target.
- Wrap-around: pc = 32'hFFFF_FFFC, handshake → next_pc = 32'h0000_0000.
- Reset mid-operation: assert rst while in S_WAIT with FIFO at 1 entry → FIFO empty and inst_valid = 0 next cycle; a response arriving after deassert is dropped; first fetch at RESET_PC.

Source files
------------

// File: rtl/smol_pkg.sv
// smol_pkg: definitions shared by the smolPC instruction-fetch front end.
//   XLEN             - architectural register / address width
//   INST_BYTES       - bytes per instruction; the sequential PC step
//   PC_STEP          - INST_BYTES widened to XLEN for PC arithmetic
//   DEFAULT_RESET_PC - PC value loaded while reset is asserted
//   fetch_state_t    - fetch request state machine encoding
//   fetch_entry_t    - one buffered instruction word with its PC
package smol_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/smol_fetch_fifo.sv
// smol_fetch_fifo: small synchronous FIFO of fetched instructions.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   push       - write push_data at the tail
//   push_data  - entry to be written
//   pop        - drop the head entry (ignored when empty)
//   flush      - discard all entries; wins over push and pop
//   full       - DEPTH entries held
//   empty      - no entries held
//   count      - current occupancy
//   head       - oldest entry (unregistered read of the storage)
module smol_fetch_fifo
  import smol_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally. A push into a
  // full FIFO is only ever paired with a pop, which frees the slot it reuses.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/smol_fetch.sv
// smol_fetch: instruction-fetch front end for smolPC.
// Reads the registered pc, issues one instruction-memory read at a time,
// buffers returned words with their PCs and hands them to decode.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   pc / next_pc                    - current PC in, PC to load next edge out
//   redirect_valid, redirect_pc     - taken branch/jump and its target
//   imem_req_valid/ready, imem_addr - memory read request handshake
//   imem_rsp_valid, imem_rsp_data   - in-order memory read response
//   inst_valid/ready, inst_data/pc  - buffered instruction towards decode
module smol_fetch
  import smol_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  fetch_state_t                  state;
  logic                          drop_flag;
  logic [XLEN-1:0]               req_pc;
  logic                          req_fire;
  logic                          rsp_push;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_unused;
  logic                          unused_ok;
  fetch_entry_t                  rsp_entry;
  fetch_entry_t                  fifo_head;

  // drop_flag blocks new requests until a response orphaned by reset has
  // come back, so at most one request is ever in flight.
  assign imem_req_valid = !rst && (state == S_REQ) && !drop_flag &&
                          !fifo_full && !redirect_valid;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc;

  // Redirect targets are forced to instruction alignment.
  always_comb begin
    if (rst)                 next_pc = RESET_PC;
    else if (redirect_valid) next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    else if (req_fire)       next_pc = pc + PC_STEP;
    else                     next_pc = pc;
  end

  // A response that coincides with a redirect belongs to the old path.
  assign rsp_push  = !rst && (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign rsp_entry = '{inst: imem_rsp_data, pc: req_pc};

  // On reset the outstanding request is forgotten, but its response may
  // still arrive later; remember to swallow it unless it lands right now.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      drop_flag <= ((state != S_REQ) || drop_flag) && !imem_rsp_valid;
      req_pc    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (drop_flag && imem_rsp_valid) drop_flag <= 1'b0;
          if (req_fire) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid)      state <= S_REQ;
          else if (redirect_valid) state <= S_DROP;
        end
        S_DROP: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  smol_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rsp_entry),
    .pop       (inst_valid && inst_ready),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused),
    .head      (fifo_head)
  );

  assign inst_valid = !rst && !fifo_empty;
  assign inst_data  = rst ? '0 : fifo_head.inst;
  assign inst_pc    = rst ? '0 : fifo_head.pc;

  assign unused_ok = ^{redirect_pc[1:0], fifo_count_unused};

endmodule

// File: tb/tb_smol_fetch.sv
// tb_smol_fetch: self-checking bench for smol_fetch.
// The bench plays smolPC (pc register loaded from next_pc), the instruction
// memory (one request at a time, programmable latency) and decode. Returned
// words are pushed to an expected queue and compared as decode sees them.
module tb_smol_fetch;
  import smol_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  // stimulus knobs for the next cycle
  logic        k_rst;
  logic        k_redir;
  logic [31:0] k_rpc;
  logic        k_dec_ready;
  logic        k_mem_ready;
  int          mem_lat;

  // memory and FIFO model
  logic         mem_pending;
  logic         mem_drop;
  logic [31:0]  mem_addr;
  int           mem_cd;
  fetch_entry_t exp_q[$];

  int total;
  int bad;

  smol_fetch #(
    .RESET_PC   (TB_RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .next_pc        (next_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // smolPC: the PC register
  always @(posedge clk) pc <= next_pc;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0000_0013;
    return {addr[31:8] ^ 24'hA5A5A5, 8'h13};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the upcoming edge.
  task automatic applyStimulus();
    logic         rsp_now;
    logic         exp_req;
    logic         hs;
    logic         exp_iv;
    logic [31:0]  exp_next;
    fetch_entry_t ent;
    @(posedge clk);
    #1;
    rsp_now        = mem_pending && (mem_cd == 0);
    rst            = k_rst;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    inst_ready     = k_dec_ready;
    imem_req_ready = k_mem_ready;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? word_at(mem_addr) : 32'hDEAD_BEEF;
    #2;
    exp_req = !k_rst && !mem_pending && (exp_q.size() < 2) && !k_redir;
    hs      = exp_req && k_mem_ready;
    exp_iv  = !k_rst && (exp_q.size() > 0);
    if (k_rst)        exp_next = TB_RESET_PC;
    else if (k_redir) exp_next = {k_rpc[31:2], 2'b00};
    else if (hs)      exp_next = pc + 32'd4;
    else              exp_next = pc;

    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
    checkOutput("next_pc", next_pc, exp_next);
    checkOutput("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_req) checkOutput("imem_addr", imem_addr, pc);
    if (exp_iv) begin
      ent = exp_q[0];
      checkOutput("inst_data", inst_data, ent.inst);
      checkOutput("inst_pc", inst_pc, ent.pc);
    end
    if (k_rst) begin
      checkOutput("rst_inst_data", inst_data, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
    end
    if (k_redir && (k_rpc == 32'h1234_5679))
      checkOutput("redir_align", next_pc, 32'h1234_5678);
    if (hs && (pc == 32'hFFFF_FFFC))
      checkOutput("wrap_next_pc", next_pc, 32'h0000_0000);

    if (k_rst || k_redir) begin
      exp_q.delete();
    end else begin
      if (exp_iv && k_dec_ready) void'(exp_q.pop_front());
      if (rsp_now && !mem_drop) begin
        ent.inst = word_at(mem_addr);
        ent.pc   = mem_addr;
        exp_q.push_back(ent);
      end
    end
    if (rsp_now) begin
      mem_pending = 1'b0;
      mem_drop    = 1'b0;
    end else if (mem_pending) begin
      if (k_rst || k_redir) mem_drop = 1'b1;
      if (mem_cd > 0) mem_cd--;
    end
    if (hs) begin
      mem_pending = 1'b1;
      mem_addr    = pc;
      mem_cd      = mem_lat;
      mem_drop    = 1'b0;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    inst_ready = 1'b0;
    k_rst = 1'b1; k_redir = 1'b0; k_rpc = 32'h0;
    k_dec_ready = 1'b1; k_mem_ready = 1'b1; mem_lat = 0;
    mem_pending = 1'b0; mem_drop = 1'b0; mem_addr = 32'h0; mem_cd = 0;

    $display("[TB] reset and first fetch");
    runCycles(2);
    k_rst = 1'b0;
    runCycles(8);

    $display("[TB] decode backpressure");
    k_dec_ready = 1'b0;
    runCycles(10);
    k_dec_ready = 1'b1;
    runCycles(8);

    $display("[TB] redirect while waiting");
    mem_lat = 3;
    n = 0;
    while (!(mem_pending && mem_cd > 0) && n < 50) begin applyStimulus(); n++; end
    checkOutput("wait_pending", 32'(mem_pending), 32'h1);
    k_redir = 1'b1; k_rpc = 32'h1234_5679;
    applyStimulus();
    k_redir = 1'b0;
    runCycles(12);

    $display("[TB] redirect coincident with response");
    mem_lat = 2;
    n = 0;
    while (!(mem_pending && mem_cd == 0) && n < 50) begin applyStimulus(); n++; end
    checkOutput("coinc_pending", 32'(mem_pending), 32'h1);
    k_redir = 1'b1; k_rpc = 32'h0000_0100;
    applyStimulus();
    k_redir = 1'b0;
    runCycles(8);

    $display("[TB] pc wrap-around");
    mem_lat = 0;
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFFC;
    applyStimulus();
    k_redir = 1'b0;
    runCycles(6);

    $display("[TB] reset mid-operation");
    k_redir = 1'b1; k_rpc = 32'h0000_0200;
    applyStimulus();
    k_redir = 1'b0;
    k_dec_ready = 1'b0;
    mem_lat = 3;
    n = 0;
    while (!(exp_q.size() == 1 && mem_pending && mem_cd > 0) && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("rst_setup", 32'(exp_q.size()), 32'h1);
    k_rst = 1'b1;
    applyStimulus();
    k_rst = 1'b0;
    k_dec_ready = 1'b1;
    runCycles(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
